// File: rtl/and4_sched.sv
// Round-robin scheduler that shares one 2-input AND datapath among NUM_REQ requesters.
// It reduces each winner's four operands over three cycles and returns the result on a valid/ready port.
module and4_sched #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*4*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        busy,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [ID_W-1:0]             rsp_id,
    input  logic                        rsp_ready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OP01 = 3'd1,
        OP23 = 3'd2,
        COMB = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [ID_W-1:0]          last_id_r;
    logic [ID_W-1:0]          id_r;
    logic [3:0][DATA_W-1:0]   opnd_r;
    logic [DATA_W-1:0]        tmp0_r;
    logic [DATA_W-1:0]        tmp1_r;
    logic [NUM_REQ-1:0]       gnt_r;
    logic                     busy_r;
    logic                     rsp_valid_r;
    logic [DATA_W-1:0]        rsp_data_r;
    logic [ID_W-1:0]          rsp_id_r;

    logic [3:0][DATA_W-1:0]   req_ops_s [NUM_REQ];
    logic                     win_found_s;
    logic [ID_W-1:0]          win_id_s;
    logic [ID_W-1:0]          cand_s;
    logic [DATA_W-1:0]        op_a_s;
    logic [DATA_W-1:0]        op_b_s;
    logic [DATA_W-1:0]        and_s;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_ops_s[i] = req_data[i*4*DATA_W +: 4*DATA_W];
    end

    // Round-robin search: first set request strictly after last_id, wrapping around.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = '0;
        cand_s      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_s = ID_W'((int'(last_id_r) + off) % NUM_REQ);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_id_s    = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Operand select for the single shared AND; idle states feed zeros.
    always_comb begin
        op_a_s = '0;
        op_b_s = '0;
        case (state_r)
            OP01:    begin op_a_s = opnd_r[0]; op_b_s = opnd_r[1]; end
            OP23:    begin op_a_s = opnd_r[2]; op_b_s = opnd_r[3]; end
            COMB:    begin op_a_s = tmp0_r;    op_b_s = tmp1_r;    end
            default: begin op_a_s = '0;        op_b_s = '0;        end
        endcase
    end

    assign and_s = op_a_s & op_b_s;

    // Next-state logic for the capture / three-step reduce / respond sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (win_found_s) state_next_s = OP01;
                else             state_next_s = IDLE;
            end
            OP01:    state_next_s = OP23;
            OP23:    state_next_s = COMB;
            COMB:    state_next_s = RESP;
            RESP: begin
                if (rsp_ready) state_next_s = IDLE;
                else           state_next_s = RESP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, capture, datapath and response registers; reset drops any in-flight job.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            last_id_r   <= ID_W'(NUM_REQ - 1);
            id_r        <= '0;
            opnd_r      <= '0;
            tmp0_r      <= '0;
            tmp1_r      <= '0;
            gnt_r       <= '0;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_id_r    <= '0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
            gnt_r   <= '0;
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        opnd_r    <= req_ops_s[win_id_s];
                        id_r      <= win_id_s;
                        last_id_r <= win_id_s;
                        gnt_r     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id_s;
                    end
                end
                OP01: tmp0_r <= and_s;
                OP23: tmp1_r <= and_s;
                COMB: begin
                    rsp_data_r  <= and_s;
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid_r <= 1'b0;
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_id    = rsp_id_r;

endmodule

// File: tb/tb_and4_sched.sv
// Self-checking bench for and4_sched: directed scenarios plus a randomized run against
// a transaction-level model (round-robin pick, 4-way AND, fixed latency, handshake).
module tb_and4_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   gnt;
    logic         busy;
    logic         rsp_valid;
    logic [7:0]   rsp_data;
    logic [1:0]   rsp_id;
    logic         rsp_ready;

    logic [7:0] ops [4][4];
    int pass_cnt = 0;
    int total    = 0;
    int m_last;

    and4_sched dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready)
    );

    for (genvar i = 0; i < 4; i++) begin : g_pack
        for (genvar k = 0; k < 4; k++) begin : g_op
            assign req_data[(i*4+k)*8 +: 8] = ops[i][k];
        end
    end

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int o = 1; o <= 4; o++) begin
            int idx;
            idx = (last + o) % 4;
            if (r[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_and(input int i);
        return ops[i][0] & ops[i][1] & ops[i][2] & ops[i][3];
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                ops[i][k] = 8'($urandom);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        req = 4'b0000;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (!busy && !rsp_valid) done = 1'b1;
            else step();
        end
        total++; if (done !== 1'b1) $display("FAIL wait_idle timeout busy=%b rsp_valid=%b", busy, rsp_valid); else pass_cnt++;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        rst_n = 1'b0; req = 4'b1111; rsp_ready = 1'b1; rand_ops();
        repeat (2) begin
            step();
            total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got=%b exp=0000", gnt); else pass_cnt++;
            total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
            total++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", rsp_valid); else pass_cnt++;
            total++; if (rsp_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", rsp_data); else pass_cnt++;
            total++; if (rsp_id !== 2'd0) $display("FAIL reset_id got=%0d exp=0", rsp_id); else pass_cnt++;
        end
        rst_n = 1'b1;
        step();
        total++; if (gnt !== 4'b0001) $display("FAIL reset_first_gnt got=%b exp=0001", gnt); else pass_cnt++;
        e = exp_and(0); m_last = 0; req = 4'b0000;
        repeat (3) step();
        total++; if (rsp_valid !== 1'b1 || rsp_data !== e || rsp_id !== 2'd0)
            $display("FAIL reset_first_rsp got v=%b d=%h id=%0d exp v=1 d=%h id=0", rsp_valid, rsp_data, rsp_id, e); else pass_cnt++;
        step();
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_first_drop got=%b exp=0", rsp_valid); else pass_cnt++;
    endtask

    task automatic test_single();
        ops[2][0] = 8'hFF; ops[2][1] = 8'hF0; ops[2][2] = 8'h3C; ops[2][3] = 8'hFF;
        req = 4'b0100; rsp_ready = 1'b1;
        step();
        total++; if (gnt !== 4'b0100 || busy !== 1'b1) $display("FAIL single_gnt got gnt=%b busy=%b exp gnt=0100 busy=1", gnt, busy); else pass_cnt++;
        req = 4'b0000; m_last = 2;
        for (int c = 1; c <= 4; c++) begin
            step();
            total++; if (rsp_valid !== (c == 3)) $display("FAIL single_valid_c%0d got=%b exp=%b", c, rsp_valid, (c == 3)); else pass_cnt++;
            total++; if (gnt !== 4'b0000) $display("FAIL single_gnt_pulse_c%0d got=%b exp=0000", c, gnt); else pass_cnt++;
        end
        total++; if (rsp_data !== 8'h30 || rsp_id !== 2'd2) $display("FAIL single_rsp got d=%h id=%0d exp d=30 id=2", rsp_data, rsp_id); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL single_busy_end got=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int prev, grants, w;
        logic [7:0] qd[$];
        int qi[$];
        rst_n = 1'b0; req = 4'b0000; step(); rst_n = 1'b1; m_last = 3;
        rand_ops(); req = 4'b1111; rsp_ready = 1'b1; prev = -1; grants = 0;
        for (int cyc = 0; cyc < 60 && !(grants == 5 && qd.size() == 0); cyc++) begin
            step();
            if (gnt !== 4'b0000) begin
                w = rr_pick(4'b1111, m_last);
                total++; if (gnt !== 4'(1 << w)) $display("FAIL rr_order grant%0d got=%b exp=%b", grants, gnt, 4'(1 << w)); else pass_cnt++;
                if (prev >= 0) begin
                    total++; if (cyc - prev !== 5) $display("FAIL rr_spacing got=%0d exp=5", cyc - prev); else pass_cnt++;
                end
                prev = cyc; m_last = w; grants++;
                qd.push_back(exp_and(w)); qi.push_back(w);
                if (grants == 5) req = 4'b0000;
            end
            if (rsp_valid === 1'b1 && qd.size() > 0) begin
                total++; if (rsp_data !== qd[0] || rsp_id !== 2'(qi[0]))
                    $display("FAIL rr_rsp got d=%h id=%0d exp d=%h id=%0d", rsp_data, rsp_id, qd[0], qi[0]); else pass_cnt++;
                void'(qd.pop_front()); void'(qi.pop_front());
            end
        end
        total++; if (grants !== 5) $display("FAIL rr_grant_count got=%0d exp=5", grants); else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        rand_ops(); e = exp_and(1);
        req = 4'b0010; rsp_ready = 1'b0;
        step();
        total++; if (gnt !== 4'b0010) $display("FAIL bp_gnt got=%b exp=0010", gnt); else pass_cnt++;
        m_last = 1;
        repeat (3) step();
        total++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid got=%b exp=1", rsp_valid); else pass_cnt++;
        repeat (10) begin
            step();
            total++; if (rsp_valid !== 1'b1 || rsp_data !== e || rsp_id !== 2'd1 || gnt !== 4'b0000 || busy !== 1'b1)
                $display("FAIL bp_hold got v=%b d=%h id=%0d gnt=%b busy=%b exp v=1 d=%h id=1 gnt=0000 busy=1",
                         rsp_valid, rsp_data, rsp_id, gnt, busy, e); else pass_cnt++;
        end
        rsp_ready = 1'b1;
        step();
        total++; if (rsp_valid !== 1'b0 || gnt !== 4'b0000) $display("FAIL bp_release got v=%b gnt=%b exp v=0 gnt=0000", rsp_valid, gnt); else pass_cnt++;
        step();
        total++; if (gnt !== 4'b0010) $display("FAIL bp_regrant got=%b exp=0010", gnt); else pass_cnt++;
        step();
        total++; if (gnt !== 4'b0000) $display("FAIL bp_regrant_pulse got=%b exp=0000", gnt); else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_midop_reset();
        logic [7:0] e;
        rand_ops(); req = 4'b0100; rsp_ready = 1'b1;
        step();
        total++; if (gnt !== 4'b0100) $display("FAIL mid_gnt got=%b exp=0100", gnt); else pass_cnt++;
        req = 4'b0000;
        step();
        rst_n = 1'b0;
        step();
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || gnt !== 4'b0000)
            $display("FAIL mid_reset got busy=%b v=%b gnt=%b exp 0 0 0000", busy, rsp_valid, gnt); else pass_cnt++;
        rst_n = 1'b1; req = 4'b1010; m_last = 3;
        step();
        total++; if (gnt !== 4'b0010) $display("FAIL mid_after_gnt got=%b exp=0010", gnt); else pass_cnt++;
        req = 4'b0000; m_last = 1; e = exp_and(1);
        repeat (2) begin
            step();
            total++; if (rsp_valid !== 1'b0) $display("FAIL mid_no_valid got=%b exp=0", rsp_valid); else pass_cnt++;
        end
        step();
        total++; if (rsp_valid !== 1'b1 || rsp_data !== e || rsp_id !== 2'd1)
            $display("FAIL mid_rsp got v=%b d=%h id=%0d exp v=1 d=%h id=1", rsp_valid, rsp_data, rsp_id, e); else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_withdraw();
        req = 4'b0001; rsp_ready = 1'b1;
        step();
        total++; if (gnt !== 4'b0001) $display("FAIL wd_gnt got=%b exp=0001", gnt); else pass_cnt++;
        m_last = 0; req = 4'b0000;
        step();
        req = 4'b1000;
        repeat (2) begin
            step();
            total++; if (gnt !== 4'b0000 || busy !== 1'b1) $display("FAIL wd_ignored got gnt=%b busy=%b exp 0000 1", gnt, busy); else pass_cnt++;
        end
        req = 4'b0000;
        wait_idle();
        req = 4'b1001;
        step();
        total++; if (gnt !== 4'b1000) $display("FAIL wd_pointer got=%b exp=1000", gnt); else pass_cnt++;
        m_last = 3;
        wait_idle();
    endtask

    task automatic test_random();
        bit m_busy, m_valid;
        int m_cnt, w;
        logic [3:0] exp_gnt;
        logic [7:0] m_data;
        logic [1:0] m_id;
        rst_n = 1'b0; req = 4'b0000; step(); rst_n = 1'b1;
        m_last = 3; m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0; m_data = 8'h00; m_id = 2'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            req = 4'($urandom); rsp_ready = ($urandom_range(0, 2) != 0); rand_ops();
            exp_gnt = 4'b0000;
            if (!m_busy) begin
                if (req != 4'b0000) begin
                    w = rr_pick(req, m_last);
                    exp_gnt = 4'(1 << w); m_last = w; m_busy = 1'b1; m_cnt = 0;
                    m_data = exp_and(w); m_id = 2'(w);
                end
            end else if (m_valid) begin
                if (rsp_ready) begin m_valid = 1'b0; m_busy = 1'b0; end
            end else begin
                m_cnt++;
                if (m_cnt == 3) m_valid = 1'b1;
            end
            step();
            total++; if (gnt !== exp_gnt || busy !== m_busy || rsp_valid !== m_valid)
                $display("FAIL rand_ctrl cyc%0d got gnt=%b busy=%b v=%b exp gnt=%b busy=%b v=%b",
                         cyc, gnt, busy, rsp_valid, exp_gnt, m_busy, m_valid); else pass_cnt++;
            if (m_valid) begin
                total++; if (rsp_data !== m_data || rsp_id !== m_id)
                    $display("FAIL rand_rsp cyc%0d got d=%h id=%0d exp d=%h id=%0d", cyc, rsp_data, rsp_id, m_data, m_id); else pass_cnt++;
            end
        end
        wait_idle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = 4'b0000; rsp_ready = 1'b1; rand_ops();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_midop_reset();
        test_withdraw();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
